apv_frame_emulator: RTL and testbench

- Transmit-side model of an APV25 analog output channel. Produces a 12-bit ADC-like sample stream: idle sync ticks, and on each trigger a digital header followed by 128 analog samples.
- Drives the readout channel's ADC data input for board self-test and bench loopback.
- Ticks and headers are compatible with the readout's sync checker and header decoder.

---
 rtl/apv_frame_emulator.sv | 170 +++++++++++++++++
 tb/tb_apv_frame_emulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apv_frame_emulator.sv
// APV25 analog output channel emulator: idle sync ticks on a fixed slot grid, and per
// queued trigger a 12-bit digital header followed by N_CHANNELS analog samples.
module apv_frame_emulator #(
    parameter int N_CHANNELS = 128,
    parameter int PEND_MAX   = 7
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ENABLE,
    input  logic        CLEAR,
    input  logic        TRIGGER,
    input  logic [7:0]  SYNC_PERIOD,
    input  logic [11:0] HIGH_LEVEL,
    input  logic [11:0] LOW_LEVEL,
    output logic [6:0]  SAMPLE_ADDR,
    input  logic [11:0] SAMPLE_DATA,
    output logic [11:0] ADC_PDATA,
    output logic        FRAME_ACTIVE,
    output logic [2:0]  PENDING,
    output logic        TRIGGER_OVERFLOW,
    output logic [7:0]  FRAME_ADDR
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        ANALOG
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  period_cnt_q, period_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic        err_latch_q, err_latch_d;
    logic [11:0] adc_q, adc_d;
    logic [6:0]  sample_addr_q, sample_addr_d;
    logic        frame_active_q, frame_active_d;
    logic [2:0]  pending_q, pending_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  frame_addr_q, frame_addr_d;

    logic        slot;
    logic        trig;
    logic        frame_start;
    logic        frame_done;
    logic [3:0]  next_bit;
    logic [11:0] hdr_word;

    assign slot     = ENABLE && (period_cnt_q == 8'd0);
    assign trig     = ENABLE && TRIGGER;
    assign next_bit = bit_idx_q + 4'd1;
    // Header bit i sits at hdr_word[11-i]: three ones, address MSB first, then no-error flag.
    assign hdr_word = {3'b111, frame_addr_q, ~err_latch_q};

    always_comb begin
        if (!ENABLE) begin
            period_cnt_d = 8'd0;
        end else if (period_cnt_q == 8'd0) begin
            period_cnt_d = SYNC_PERIOD;
        end else begin
            period_cnt_d = period_cnt_q - 8'd1;
        end
    end

    // bit_idx is the index of the header bit currently on ADC_PDATA; the start edge drives bit 0.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        bit_idx_d      = bit_idx_q;
        adc_d          = LOW_LEVEL;
        sample_addr_d  = sample_addr_q;
        frame_active_d = frame_active_q;
        frame_start    = 1'b0;
        frame_done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                frame_active_d = 1'b0;
                sample_addr_d  = 7'd0;
                if (slot) begin
                    adc_d = HIGH_LEVEL;
                    if (pending_q != 3'd0) begin
                        state_d        = HEADER;
                        bit_idx_d      = 4'd0;
                        frame_active_d = 1'b1;
                        frame_start    = 1'b1;
                    end
                end
            end
            HEADER: begin
                bit_idx_d = next_bit;
                adc_d     = hdr_word[4'd11 - next_bit] ? HIGH_LEVEL : LOW_LEVEL;
                if (next_bit == 4'd11) begin
                    sample_addr_d = 7'd0;
                    state_d       = ANALOG;
                end
            end
            ANALOG: begin
                adc_d         = SAMPLE_DATA;
                sample_addr_d = sample_addr_q + 7'd1;
                if (sample_addr_q == 7'(N_CHANNELS - 1)) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Trigger queue and frame bookkeeping; a lost trigger is set after the end-of-frame clear.
    always_comb begin
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        err_latch_d  = err_latch_q;
        frame_addr_d = frame_addr_q;
        if (frame_done) begin
            frame_addr_d = frame_addr_q + 8'd1;
            err_latch_d  = 1'b0;
        end
        if (trig && !frame_start) begin
            if (pending_q == 3'(PEND_MAX)) begin
                overflow_d  = 1'b1;
                err_latch_d = 1'b1;
            end else begin
                pending_d = pending_q + 3'd1;
            end
        end else if (!trig && frame_start) begin
            pending_d = pending_q - 3'd1;
        end
        if (CLEAR) begin
            pending_d    = 3'd0;
            overflow_d   = 1'b0;
            err_latch_d  = 1'b0;
            frame_addr_d = 8'd0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q        <= IDLE;
            period_cnt_q   <= 8'd0;
            bit_idx_q      <= 4'd0;
            err_latch_q    <= 1'b0;
            adc_q          <= 12'd0;
            sample_addr_q  <= 7'd0;
            frame_active_q <= 1'b0;
            pending_q      <= 3'd0;
            overflow_q     <= 1'b0;
            frame_addr_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            bit_idx_q      <= bit_idx_d;
            err_latch_q    <= err_latch_d;
            adc_q          <= adc_d;
            sample_addr_q  <= sample_addr_d;
            frame_active_q <= frame_active_d;
            pending_q      <= pending_d;
            overflow_q     <= overflow_d;
            frame_addr_q   <= frame_addr_d;
        end
    end

    assign SAMPLE_ADDR      = sample_addr_q;
    assign ADC_PDATA        = adc_q;
    assign FRAME_ACTIVE     = frame_active_q;
    assign PENDING          = pending_q;
    assign TRIGGER_OVERFLOW = overflow_q;
    assign FRAME_ADDR       = frame_addr_q;

endmodule

// File: tb/tb_apv_frame_emulator.sv
// Directed bench for apv_frame_emulator: ticks, single frame, queue, overflow, clear, wrap, reset.
module tb_apv_frame_emulator;

    localparam logic [11:0] HI = 12'd3500;
    localparam logic [11:0] LO = 12'd500;

    logic        clk;
    logic        rst_b;
    logic        enable;
    logic        clear;
    logic        trigger;
    logic [7:0]  sync_period;
    logic [11:0] high_level;
    logic [11:0] low_level;
    logic [6:0]  sample_addr;
    logic [11:0] sample_data;
    logic [11:0] adc_pdata;
    logic        frame_active;
    logic [2:0]  pending;
    logic        trigger_overflow;
    logic [7:0]  frame_addr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int grid     = 0;
    logic [7:0] exp_fa;

    apv_frame_emulator dut (
        .CLK              (clk),
        .RSTb             (rst_b),
        .ENABLE           (enable),
        .CLEAR            (clear),
        .TRIGGER          (trigger),
        .SYNC_PERIOD      (sync_period),
        .HIGH_LEVEL       (high_level),
        .LOW_LEVEL        (low_level),
        .SAMPLE_ADDR      (sample_addr),
        .SAMPLE_DATA      (sample_data),
        .ADC_PDATA        (adc_pdata),
        .FRAME_ACTIVE     (frame_active),
        .PENDING          (pending),
        .TRIGGER_OVERFLOW (trigger_overflow),
        .FRAME_ADDR       (frame_addr)
    );

    // Pattern source: sample k carries code 2000+k.
    assign sample_data = 12'd2000 + {5'd0, sample_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One trigger per frame, each issued while the previous frame runs, so frames go back to back.
    task automatic advance_frames(input int n);
        logic found;
        for (int k = 0; k < n; k++) begin
            trigger = 1'b1;
            step();
            trigger = 1'b0;
            found = 1'b0;
            for (int j = 0; j < 200; j++) begin
                if (pending == 3'd0) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            check("ff_frame_start", {31'd0, found}, 32'd1);
        end
        exp_fa = exp_fa + 8'(n);
        found = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (frame_addr == exp_fa) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("ff_frame_addr", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [11:0] hdr_5a;
        logic        found;
        hdr_5a      = 12'b1110_1011_0101;
        rst_b       = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        trigger     = 1'b0;
        sync_period = 8'd34;
        high_level  = HI;
        low_level   = LO;
        exp_fa      = 8'h00;

        // Reset values
        #2;
        check("rst_adc", adc_pdata, 0);
        check("rst_addr", sample_addr, 0);
        check("rst_active", frame_active, 0);
        check("rst_pending", pending, 0);
        check("rst_ovf", trigger_overflow, 0);
        check("rst_fa", frame_addr, 0);
        step_n(2);
        rst_b = 1'b1;
        step();
        check("dis_low", adc_pdata, LO);

        // Idle ticks: first tick one clock after enable, then every 35 clocks
        enable = 1'b1;
        step();
        check("tick_first", adc_pdata, HI);
        grid = cyc;
        for (int i = 1; i <= 70; i++) begin
            step();
            check("tick_grid", adc_pdata, (i % 35 == 0) ? HI : LO);
            check("tick_inactive", frame_active, 0);
        end

        advance_frames(90);
        check("fa_5a", frame_addr, 8'h5A);

        // Single frame at address 0x5A
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("single_pending", pending, 1);
        found = 1'b0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (frame_active) begin
                found = 1'b1;
                break;
            end
        end
        check("single_start", {31'd0, found}, 1);
        check("single_on_slot", (cyc - grid) % 35, 0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            check("hdr_5a", adc_pdata, hdr_5a[11 - i] ? HI : LO);
            check("hdr_active", frame_active, 1);
        end
        for (int k = 0; k < 128; k++) begin
            step();
            check("sample", adc_pdata, 2000 + k);
            check("sample_active", frame_active, 1);
        end
        check("fa_5b", frame_addr, 8'h5B);
        step();
        check("post_tick", adc_pdata, HI);
        check("post_inactive", frame_active, 0);
        check("post_on_slot", (cyc - grid) % 35, 0);

        // Queue: three triggers within five clocks, three back-to-back frames
        trigger = 1'b1; step();
        trigger = 1'b0; step();
        trigger = 1'b1; step();
        trigger = 1'b0; step();
        trigger = 1'b1; step();
        trigger = 1'b0;
        check("q_pending3", pending, 3);
        step_n(30);
        check("q_f1_slot", (cyc - grid) % 35, 0);
        check("q_f1_active", frame_active, 1);
        check("q_f1_pending", pending, 2);
        check("q_f1_adc", adc_pdata, HI);
        step_n(140);
        check("q_f2_active", frame_active, 1);
        check("q_f2_pending", pending, 1);
        check("q_f2_adc", adc_pdata, HI);
        step_n(140);
        check("q_f3_active", frame_active, 1);
        check("q_f3_pending", pending, 0);
        step_n(140);
        check("q_end_tick", adc_pdata, HI);
        check("q_end_inactive", frame_active, 0);
        check("q_fa_5e", frame_addr, 8'h5E);

        // Overflow: nine triggers, two dropped
        trigger = 1'b1;
        step_n(9);
        trigger = 1'b0;
        check("ovf_pending7", pending, 7);
        check("ovf_flag", trigger_overflow, 1);
        step_n(26);
        check("ovf_f1_slot", (cyc - grid) % 35, 0);
        check("ovf_f1_active", frame_active, 1);
        check("ovf_f1_pending", pending, 6);
        step_n(11);
        check("ovf_f1_bit11", adc_pdata, LO);
        step_n(129);
        check("ovf_f2_active", frame_active, 1);
        check("ovf_f2_pending", pending, 5);
        step_n(11);
        check("ovf_f2_bit11", adc_pdata, HI);
        check("ovf_sticky", trigger_overflow, 1);
        step_n(127);

        // Clear with simultaneous trigger on the final sample edge
        clear   = 1'b1;
        trigger = 1'b1;
        step();
        clear   = 1'b0;
        trigger = 1'b0;
        check("clr_last_sample", adc_pdata, 2127);
        check("clr_active", frame_active, 1);
        check("clr_fa", frame_addr, 0);
        check("clr_pending", pending, 0);
        check("clr_ovf", trigger_overflow, 0);
        step();
        check("clr_tick", adc_pdata, HI);
        check("clr_inactive", frame_active, 0);
        exp_fa = 8'h00;

        advance_frames(255);
        check("fa_ff", frame_addr, 8'hFF);

        // Wrap, and trigger on the frame-start edge
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("wrap_pending1", pending, 1);
        for (int j = 0; j < 40; j++) begin
            if ((cyc + 1 - grid) % 35 == 0) break;
            step();
        end
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("wrap_active", frame_active, 1);
        check("wrap_pending_same", pending, 1);
        check("wrap_bit0", adc_pdata, HI);
        for (int i = 1; i < 12; i++) begin
            step();
            check("wrap_hdr_ff", adc_pdata, HI);
        end
        step_n(128);
        check("wrap_fa_00", frame_addr, 8'h00);
        step();
        check("wrap_f2_active", frame_active, 1);
        check("wrap_f2_pending", pending, 0);

        // Reset mid-analog at SAMPLE_ADDR=60
        step_n(71);
        check("mid_addr60", sample_addr, 60);
        check("mid_sample59", adc_pdata, 2059);
        rst_b  = 1'b0;
        enable = 1'b0;
        #1;
        check("mid_rst_adc", adc_pdata, 0);
        check("mid_rst_addr", sample_addr, 0);
        check("mid_rst_active", frame_active, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_ovf", trigger_overflow, 0);
        check("mid_rst_fa", frame_addr, 0);
        step();
        rst_b = 1'b1;
        step();
        check("rel_dis_low", adc_pdata, LO);
        enable = 1'b1;
        step();
        check("rel_first_tick", adc_pdata, HI);
        step_n(34);
        check("rel_gap_low", adc_pdata, LO);
        step();
        check("rel_second_tick", adc_pdata, HI);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
